image_blend_stream: RTL
=======================

IMAGE_BLEND_STREAM -- requirements
Module: image_blend_stream

Interface
REQ-001: The block SHALL have parameter PIX_W, default 8, giving the bits per channel sample.
REQ-002: The block SHALL have parameter CH, default 1 (legal 1..4), giving the channels per pixel.
REQ-003: The block SHALL have parameter IMG_W, default 512, giving the pixels per line.
REQ-004: The block SHALL have parameter IMG_H, default 512, giving the lines per frame.
REQ-005: The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006: The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007: The block SHALL have port s_valid, input, 1 bit: the input beat is valid.
REQ-008: The block SHALL have port s_ready, output, 1 bit: the block accepts the input beat.
REQ-009: The block SHALL have port s_a, input, CH*PIX_W bits: image-0 pixel, channel 0 in the LSBs.
REQ-010: The block SHALL have port s_b, input, CH*PIX_W bits: image-1 pixel, same packing as s_a.
REQ-011: The block SHALL have port s_alpha, input, PIX_W+1 bits: blend weight, shared by all channels.
REQ-012: The block SHALL have port mode, input, 1 bit: 0 = raw product a*b, 1 = alpha blend.
REQ-013: The block SHALL have port m_valid, output, 1 bit: the output beat is valid.
REQ-014: The block SHALL have port m_ready, input, 1 bit: downstream accepts the output beat.
REQ-015: The block SHALL have port m_data, output, CH*2*PIX_W bits: per-channel result, channel 0 in the LSBs.
REQ-016: The block SHALL have port m_last, output, 1 bit: the current output beat is the last pixel of the frame.
REQ-017: The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when the last beat is accepted.
REQ-018: The block SHALL have port pix_cnt, output, clog2(IMG_W*IMG_H) bits: count of input beats accepted in the current frame.

Function
REQ-019: An input beat SHALL be accepted when s_valid and s_ready are both 1 on a clock edge, and an output beat SHALL be transferred when m_valid and m_ready are both 1.
REQ-020: The block SHALL be a two-stage pipeline: S1 registers per-channel products, S2 registers the sum/shift result; enable = !m_valid || m_ready.
REQ-021: s_ready SHALL equal enable, combinationally, with no dependence on s_valid.
REQ-022: With no stall, an accepted beat SHALL appear on m_data with m_valid=1 exactly 2 cycles after acceptance.
REQ-023: While enable=0, both pipeline stages SHALL hold their contents, and m_data/m_last SHALL remain stable.
REQ-024: Beats SHALL leave the block in acceptance order, with none dropped or duplicated.
REQ-025: Sustained s_valid=1 with m_ready=1 SHALL give a throughput of one beat per cycle.
REQ-026: In mode 0, each channel SHALL output r = a*b, unsigned, 2*PIX_W bits wide.
REQ-027: In mode 1, each channel SHALL output r = (a*al + b*(2^PIX_W - al)) >> PIX_W, truncated and zero-extended to 2*PIX_W bits.
REQ-028: In mode 1, al = min(s_alpha, 2^PIX_W), so any s_alpha above 2^PIX_W SHALL be clamped to 2^PIX_W.
REQ-029: Mode SHALL be latched on the beat accepted while pix_cnt=0 and held for the whole frame; mode changes mid-frame SHALL be ignored until the next frame.
REQ-030: pix_cnt SHALL increment on each accepted beat, and the beat accepted at pix_cnt = IMG_W*IMG_H-1 SHALL wrap pix_cnt to 0.
REQ-031: The beat accepted at pix_cnt = IMG_W*IMG_H-1 SHALL carry a last tag through the pipeline, and m_last=1 SHALL be asserted with that beat's output.
REQ-032: frame_done SHALL pulse high for exactly one cycle, in the cycle after m_valid & m_ready & m_last.
REQ-033: Acceptance of the first beat of the next frame in the same cycle as the previous frame's last output SHALL be legal, with no bubble and no mode corruption.
REQ-034: All multiplies SHALL be exact, unsigned, and full width; there SHALL be no overflow, since the mode-1 sum is at most (2^PIX_W-1)*2^PIX_W.

Reset
REQ-035: When rst=1 on a clock edge, the block SHALL clear both pipeline valid bits, m_valid, m_last, frame_done, pix_cnt, the latched mode, and m_data.
REQ-036: In the cycle after reset deasserts, s_ready SHALL be 1.
REQ-037: A reset mid-frame or mid-stall SHALL discard all in-flight beats, and the next accepted beat SHALL be treated as pixel 0 of a new frame.

Verification
REQ-038: The bench SHALL apply PIX_W=8, CH=1, mode=0, a=0xFF, b=0xFF, m_ready=1 and check m_data=0xFE01 two cycles after acceptance.
REQ-039: The bench SHALL apply mode=1, a=200, b=100, s_alpha=64 and check m_data=0x007D (125); with s_alpha=300 (clamped) it SHALL check m_data=0x00C8 (200).
REQ-040: The bench SHALL use IMG_W=4, IMG_H=2, send 8 beats continuously, and check that m_last=1 only on the 8th output, frame_done pulses once in the following cycle, and pix_cnt returns to 0.
REQ-041: The bench SHALL hold m_ready=0 for 5 cycles with the pipeline full and check that s_ready=0, the outputs are held stable, no beat is lost, and the order is preserved after release.
REQ-042: The bench SHALL toggle mode at pixel 3 of an 8-pixel frame and check that the whole frame uses the mode latched at pixel 0, and the next frame uses the new mode.
REQ-043: The bench SHALL assert rst for 1 cycle with 2 beats in flight and check that m_valid=0 afterwards, no stale beat emerges, and the next beat is counted as pix_cnt 0→1.

Source files
------------

// File: rtl/image_blend_stream.sv
// Two-stage streaming pixel combiner: per-channel raw product or alpha blend of two images,
// with per-frame mode latching, pixel counting and end-of-frame tagging.
module image_blend_stream #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned CH    = 1,
    parameter int unsigned IMG_W = 512,
    parameter int unsigned IMG_H = 512,
    localparam int unsigned NPIX  = IMG_W * IMG_H,
    localparam int unsigned CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [CH*PIX_W-1:0]     s_a,
    input  logic [CH*PIX_W-1:0]     s_b,
    input  logic [PIX_W:0]          s_alpha,
    input  logic                    mode,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [CH*2*PIX_W-1:0]   m_data,
    output logic                    m_last,
    output logic                    frame_done,
    output logic [CNT_W-1:0]        pix_cnt
);

    localparam int unsigned        PW2      = 2 * PIX_W;
    localparam logic [PIX_W:0]     AL_MAX   = {1'b1, {PIX_W{1'b0}}};
    localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(NPIX - 1);

    logic                   enable, accept, first_pix, last_pix, eff_mode;
    logic [PIX_W:0]         al, al_inv;
    logic [PW2-1:0]         a_x, b_x, al_x, inv_x, sum;
    logic [CH-1:0][PW2-1:0] pa_d, pa_q, pb_d, pb_q;
    logic                   v1_d, v1_q, last1_d, last1_q, mode1_d, mode1_q;
    logic                   m_valid_d, m_valid_q, m_last_d, m_last_q;
    logic                   frame_done_d, frame_done_q, mode_d, mode_q;
    logic [CH*PW2-1:0]      m_data_d, m_data_q;
    logic [CNT_W-1:0]       pix_cnt_d, pix_cnt_q;

    // Stage 1: products, frame bookkeeping
    always_comb begin
        enable    = !m_valid_q || m_ready;
        accept    = s_valid && enable;
        first_pix = (pix_cnt_q == '0);
        last_pix  = (pix_cnt_q == LAST_IDX);
        // Pixel 0 uses the live mode; the rest of the frame uses the value latched with it.
        eff_mode  = first_pix ? mode : mode_q;
        al        = (s_alpha > AL_MAX) ? AL_MAX : s_alpha;
        al_inv    = AL_MAX - al;
        al_x      = PW2'(al);
        inv_x     = PW2'(al_inv);
        a_x       = '0;
        b_x       = '0;
        pa_d      = pa_q;
        pb_d      = pb_q;
        v1_d      = v1_q;
        last1_d   = last1_q;
        mode1_d   = mode1_q;
        if (enable) begin
            v1_d    = s_valid;
            last1_d = accept && last_pix;
            mode1_d = eff_mode;
            for (int c = 0; c < int'(CH); c++) begin
                a_x     = PW2'(s_a[c*PIX_W +: PIX_W]);
                b_x     = PW2'(s_b[c*PIX_W +: PIX_W]);
                pa_d[c] = eff_mode ? a_x * al_x : a_x * b_x;
                pb_d[c] = eff_mode ? b_x * inv_x : '0;
            end
        end
        pix_cnt_d = pix_cnt_q;
        mode_d    = mode_q;
        if (accept) begin
            pix_cnt_d = last_pix ? '0 : pix_cnt_q + 1'b1;
            if (first_pix) mode_d = mode;
        end
    end

    // Stage 2: sum and shift
    always_comb begin
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        sum       = '0;
        if (enable) begin
            m_valid_d = v1_q;
            m_last_d  = last1_q;
            for (int c = 0; c < int'(CH); c++) begin
                sum                    = pa_q[c] + pb_q[c];
                m_data_d[c*PW2 +: PW2] = mode1_q ? (sum >> PIX_W) : pa_q[c];
            end
        end
        frame_done_d = m_valid_q && m_ready && m_last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q         <= 1'b0;
            last1_q      <= 1'b0;
            mode1_q      <= 1'b0;
            pa_q         <= '0;
            pb_q         <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_data_q     <= '0;
            frame_done_q <= 1'b0;
            mode_q       <= 1'b0;
            pix_cnt_q    <= '0;
        end else begin
            v1_q         <= v1_d;
            last1_q      <= last1_d;
            mode1_q      <= mode1_d;
            pa_q         <= pa_d;
            pb_q         <= pb_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_data_q     <= m_data_d;
            frame_done_q <= frame_done_d;
            mode_q       <= mode_d;
            pix_cnt_q    <= pix_cnt_d;
        end
    end

    assign s_ready    = enable;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign m_data     = m_data_q;
    assign frame_done = frame_done_q;
    assign pix_cnt    = pix_cnt_q;

endmodule
